// File: rtl/dac_spi_writer_pkg.sv
// Shared definitions for the dual-channel DAC SPI writer: FSM states,
// frame-word layout and a helper that assembles one 16-bit command word.
package dac_pkg;

    localparam int WORD_LEN   = 16;
    localparam int CODE_W     = 12;

    // Command bit positions inside the 16-bit frame word.
    localparam int SEL_BIT    = 15;
    localparam int BUF_BIT    = 14;
    localparam int GA_N_BIT   = 13;
    localparam int SHDN_N_BIT = 12;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_A,
        GAP_A,
        SHIFT_B,
        GAP_B,
        LDAC,
        DONE
    } state_t;

    // Builds {sel, buf, ga_n, shdn_n=1, code}.
    function automatic logic [WORD_LEN-1:0] make_frame(
        input logic              sel,
        input logic              buf_en,
        input logic              ga_n,
        input logic [CODE_W-1:0] code
    );
        logic [WORD_LEN-1:0] w;
        w              = '0;
        w[SEL_BIT]     = sel;
        w[BUF_BIT]     = buf_en;
        w[GA_N_BIT]    = ga_n;
        w[SHDN_N_BIT]  = 1'b1;
        w[CODE_W-1:0]  = code;
        return w;
    endfunction

endpackage

// File: rtl/dac_spi_writer_if.sv
// Host-side request/status signals plus the DAC-side SPI pins of the writer.
interface dac_spi_writer_if;
    import dac_pkg::*;

    logic              load;
    logic [CODE_W-1:0] code_a;
    logic [CODE_W-1:0] code_b;
    logic              cs_n;
    logic              sclk;
    logic              sdi;
    logic              ldac_n;
    logic              busy;
    logic              done;
    logic              overrun;

    // Host side: issues update requests and watches the pins/status.
    modport master (
        output load, code_a, code_b,
        input  cs_n, sclk, sdi, ldac_n, busy, done, overrun
    );

    // Writer side: consumes requests and drives the DAC pins/status.
    modport slave (
        input  load, code_a, code_b,
        output cs_n, sclk, sdi, ldac_n, busy, done, overrun
    );

endinterface

// File: rtl/dac_spi_writer_bit_timer.sv
// SCLK phase generator: while running, toggles sclk every CLK_DIV cycles
// (starting low) and flags the end of each full bit period.
module spi_bit_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    output logic sclk,
    output logic bit_tick,
    output logic idle
);

    logic       running;
    logic       phase;
    logic [7:0] div_cnt;
    logic       half_end;

    assign half_end = running && (div_cnt == 8'(CLK_DIV - 1));

    // Half-period counter and sclk phase; stop forces sclk low immediately.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (rst || stop) begin
            running <= 1'b0;
            phase   <= 1'b0;
            div_cnt <= '0;
        end else if (start) begin
            running <= 1'b1;
            phase   <= 1'b0;
            div_cnt <= '0;
        end else if (half_end) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else if (running) begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    assign sclk     = phase;
    // End of the high half: the next bit goes out together with the falling edge.
    assign bit_tick = half_end && phase;
    assign idle     = !running;

endmodule

// File: rtl/dac_spi_writer.sv
// Dual-channel DAC writer: on load, captures both codes and sends frame A,
// a cs_n gap, frame B, a second gap, then strobes ldac_n to latch both.
module dac_spi_writer
    import dac_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2,
    parameter int LDAC_W  = 2,
    parameter int GAIN_1X = 1,
    parameter int BUF_EN  = 0
) (
    input logic             clk,
    input logic             rst,
    dac_spi_writer_if.slave bus
);

    state_t              state;
    state_t              next_state;
    logic [CODE_W-1:0]   code_b_q;
    logic [WORD_LEN-1:0] shift_q;
    logic [3:0]          bit_cnt;
    logic [7:0]          cnt_q;
    logic                overrun_q;

    logic t_start;
    logic t_stop;
    logic t_sclk;
    logic t_tick;
    logic t_idle;

    logic shifting;
    logic busy_w;
    logic last_bit;

    assign shifting = (state == SHIFT_A) || (state == SHIFT_B);
    assign busy_w   = (state != IDLE) && (state != DONE);
    assign last_bit = t_tick && (bit_cnt == 4'd0);

    spi_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (t_start),
        .stop     (t_stop),
        .sclk     (t_sclk),
        .bit_tick (t_tick),
        .idle     (t_idle)
    );

    // Next-state logic and timer control for the fixed transfer sequence.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        next_state = state;
        t_start    = 1'b0;
        t_stop     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    next_state = SHIFT_A;
                    t_start    = t_idle;
                end
            end
            SHIFT_A: begin
                if (last_bit) begin
                    next_state = GAP_A;
                    t_stop     = 1'b1;
                end
            end
            GAP_A: begin
                if (cnt_q == 8'(CS_GAP - 1)) begin
                    next_state = SHIFT_B;
                    t_start    = t_idle;
                end
            end
            SHIFT_B: begin
                if (last_bit) begin
                    next_state = GAP_B;
                    t_stop     = 1'b1;
                end
            end
            GAP_B: begin
                if (cnt_q == 8'(CS_GAP - 1)) begin
                    next_state = LDAC;
                end
            end
            LDAC: begin
                // LDAC_W cycles low plus one release cycle before DONE.
                if (cnt_q == 8'(LDAC_W)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register, code capture, shift register and cycle counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            code_b_q  <= '0;
            shift_q   <= '0;
            bit_cnt   <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state     <= next_state;
            overrun_q <= bus.load && busy_w;

            if (next_state != state) begin
                cnt_q <= '0;
            end else if ((state == GAP_A) || (state == GAP_B) || (state == LDAC)) begin
                cnt_q <= cnt_q + 8'd1;
            end

            case (state)
                IDLE: begin
                    // Channel A goes straight into the shift register so its
                    // MSB is on sdi in the first SHIFT_A cycle; B waits in code_b_q.
                    if (bus.load) begin
                        code_b_q <= bus.code_b;
                        shift_q  <= make_frame(1'b0, BUF_EN != 0, GAIN_1X != 0, bus.code_a);
                        bit_cnt  <= 4'(WORD_LEN - 1);
                    end
                end
                GAP_A: begin
                    if (next_state == SHIFT_B) begin
                        shift_q <= make_frame(1'b1, BUF_EN != 0, GAIN_1X != 0, code_b_q);
                        bit_cnt <= 4'(WORD_LEN - 1);
                    end
                end
                SHIFT_A, SHIFT_B: begin
                    if (t_tick) begin
                        if (bit_cnt == 4'd0) begin
                            shift_q <= '0;
                        end else begin
                            shift_q <= {shift_q[WORD_LEN-2:0], 1'b0};
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cs_n    = !shifting;
    assign bus.sclk    = t_sclk;
    assign bus.sdi     = shifting ? shift_q[WORD_LEN-1] : 1'b0;
    assign bus.ldac_n  = !((state == LDAC) && (cnt_q < 8'(LDAC_W)));
    assign bus.busy    = busy_w;
    assign bus.done    = (state == DONE);
    assign bus.overrun = overrun_q;

endmodule
